demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for the 1-to-4 demultiplexer datapath.
- Accepts a valid/ready input stream and decides, per item, which of four output channels receives it: directed by a destination field, or round-robin across enabled channels.
- Holds the item in a one-entry output register until the selected consumer accepts it.
- Keeps per-channel delivery counters.
- Sits between the pipeline producer and four consumers (e.g. functional units or write ports).

Parameters:
- DATA_W, 32, payload width.
- COUNT_W, 8, width of each per-channel delivery counter.
- TIMEOUT, 16, hold cycles before drop; used only with the optional feature; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = directed (use in_dest), 1 = round-robin.
- chan_en  in  4  per-channel enable mask.
- in_valid  in  1  producer has an item.
- in_ready  out  1  controller can accept this cycle.
- in_data  in  DATA_W  payload.
- in_dest  in  2  destination channel (directed mode).
- out_valid  out  4  one-hot valid, at most one bit set.
- out_ready  in  4  per-channel consumer ready.
- out_data  out  DATA_W  payload of held item, shared by all channels.
- out_sel  out  2  index of held item's channel (demux select).
- err_pulse  out  1  one-cycle pulse: directed item to disabled channel discarded.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_out  out  4*COUNT_W  counters; channel k at bits [k*COUNT_W +: COUNT_W].

Behaviour:
- Reset: all outputs 0 (in_ready 0 during reset), state IDLE, RR pointer 0, counters 0. Reset mid-HOLD discards the held item with no pulse.
- States:
  - IDLE: buffer empty.
  - HOLD: buffer full, out_valid[out_sel] = 1.
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid[out_sel] & out_ready[out_sel].
- in_ready = (state==IDLE | (state==HOLD & out_ready[out_sel])) & channel_available. This is a combinational path from out_ready and is permitted.
- channel_available:
  - Directed mode: always 1.
  - RR mode: chan_en != 0.
- Channel choice (mode sampled at acceptance):
  - Directed: ch = in_dest.
  - RR: first enabled channel at or after the pointer, searching upward with wrap 3->0.
- Directed item with chan_en[in_dest]==0:
  - Accepted, not loaded into the buffer.
  - err_pulse = 1 in the next cycle.
  - State unchanged, except that a buffer draining in the same cycle goes to IDLE.
- Latency: an item accepted in cycle N shows out_valid at N+1. Throughput is 1 item/cycle when the consumer is ready.
- HOLD -> IDLE on output handshake with no simultaneous acceptance. HOLD -> HOLD (reloaded) on simultaneous output handshake and input acceptance.
- RR pointer: on a loading RR acceptance, pointer = chosen channel + 1 mod 4. Directed items never move the pointer.
- Clearing chan_en while in HOLD does not revoke the held item; it stays until accepted.
- out_data/out_sel stable throughout HOLD. In IDLE they retain their last value; out_valid = 0.
- Counters: counter[out_sel] += 1 on each output handshake, saturating at 2^COUNT_W-1.
- cnt_clr clears all counters and wins over a same-cycle increment.
- mode changes take effect only for the next accepted item.

Optional Feature:
- Macro: DEMUX_DISPATCH_TIMEOUT_EN.
- Defined:
  - Adds output drop_pulse (1 bit) and a hold-cycle counter that counts cycles in HOLD without an output handshake.
  - When the count reaches TIMEOUT, the item is discarded, state -> IDLE and drop_pulse = 1 for one cycle. No counter increment.
  - Counter resets on every load.
- Not defined: no port, no counter; an item is held indefinitely.

Decomposition:
- Package demux_dispatch_pkg:
  - NUM_CH = 4, SEL_W = 2.
  - state enum {IDLE, HOLD}.
  - mode constants MODE_DIRECTED = 0, MODE_RR = 1.
- Sub-module dispatch_rr_pick: combinational; inputs pointer[1:0] and chan_en[3:0]; outputs chosen index[1:0] and found.

Test Plan:
- Directed, all out_ready=1, chan_en=4'hF; send dest 0,1,2,3 with data 0xA0..0xA3 -> out_valid one-hot 1,2,4,8 on consecutive cycles, each one cycle after acceptance; cnt_out each = 1.
- RR mode, chan_en=4'b1010, 4 items -> channels 1,3,1,3; pointer skips 0 and 2.
- Backpressure: directed dest 2 data 0x55, out_ready[2]=0 for 5 cycles -> out_valid=4'b0100 and out_data=0x55 held stable; in_ready=0; on ready, handshake and back-to-back reload.
- Directed dest 1 with chan_en=4'b1101 -> item accepted, no out_valid, err_pulse one cycle; RR mode with chan_en=0 -> in_ready=0.
- COUNT_W=2: 5 handshakes on channel 0 -> counter saturates at 3; cnt_clr with a simultaneous handshake -> counter 0.
- Reset asserted in HOLD -> next cycle out_valid=0, counters 0, pointer 0. With DEMUX_DISPATCH_TIMEOUT_EN and TIMEOUT=4, out_ready=0 -> drop_pulse after 4 hold cycles, state IDLE.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatch controller.
package demux_dispatch_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  function automatic logic [NUM_CH-1:0] sel2onehot(input logic [SEL_W-1:0] s);
    logic [NUM_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/dispatch_rr_pick.sv
// Round-robin channel picker: first enabled channel at or after ptr, wrapping 3->0.
module dispatch_rr_pick
  import demux_dispatch_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] chan_en,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);
  logic [SEL_W-1:0] cand;

  // Walk offsets from far to near so the nearest enabled channel wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (chan_en[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for the 1-to-4 demux: one-entry hold buffer, directed/RR steering,
// saturating per-channel counters. Optional hold timeout under DEMUX_DISPATCH_TIMEOUT_EN.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [NUM_CH-1:0]         chan_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_dest,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      err_pulse,
  input  logic                      cnt_clr,
  output logic [NUM_CH*COUNT_W-1:0] cnt_out
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
  ,
  output logic                      drop_pulse
`endif
);
  state_t                          state, state_nx;
  logic [SEL_W-1:0]                rr_ptr, pick_idx, tgt;
  logic                            pick_found, chan_avail, out_hs;
  logic                            accept, bad_dest, load, timeout;
  logic [NUM_CH-1:0][COUNT_W-1:0]  cnt;

  if (TIMEOUT < 1) begin : g_timeout_must_be_positive
  end

  dispatch_rr_pick u_pick (
    .ptr     (rr_ptr),
    .chan_en (chan_en),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign chan_avail = (mode == MODE_RR) ? pick_found : 1'b1;
  assign out_hs     = (state == HOLD) & out_ready[out_sel];
  // Refill in the same cycle the held item drains, so the consumer sees 1 item/cycle.
  assign in_ready   = ~reset & ((state == IDLE) | out_hs) & chan_avail;
  assign accept     = in_valid & in_ready;
  assign tgt        = (mode == MODE_RR) ? pick_idx : in_dest;
  assign bad_dest   = (mode == MODE_DIRECTED) & ~chan_en[in_dest];
  assign load       = accept & ~bad_dest;
  assign out_valid  = (state == HOLD) ? sel2onehot(out_sel) : '0;
  assign cnt_out    = cnt;

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
  localparam int HC_W = $clog2(TIMEOUT + 1);
  logic [HC_W-1:0] hold_cnt;

  assign timeout = (state == HOLD) & ~out_hs & (hold_cnt == HC_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= timeout;
      if (load)
        hold_cnt <= '0;
      else if ((state == HOLD) & ~out_hs)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = HOLD;
      HOLD: begin
        if (load)                   state_nx = HOLD;
        else if (out_hs | timeout)  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Directed items never move the pointer; only a loading RR pick advances it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept & bad_dest;
      if (load) begin
        out_data <= in_data;
        out_sel  <= tgt;
        if (mode == MODE_RR) rr_ptr <= pick_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset | cnt_clr) begin
      cnt <= '0;
    end else if (out_hs) begin
      for (int k = 0; k < NUM_CH; k++)
        if ((out_sel == SEL_W'(k)) && (cnt[k] != '1))
          cnt[k] <= cnt[k] + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl (COUNT_W=2, TIMEOUT=4).
module tb_demux_dispatch_ctrl;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 2;

  logic                 clk = 1'b0;
  logic                 reset, mode, in_valid, in_ready, err_pulse, cnt_clr;
  logic [3:0]           chan_en, out_valid, out_ready;
  logic [DATA_W-1:0]    in_data, out_data;
  logic [1:0]           in_dest, out_sel;
  logic [4*COUNT_W-1:0] cnt_out;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
  logic                 drop_pulse;
`endif

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .chan_en(chan_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .err_pulse(err_pulse), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    , .drop_pulse(drop_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] ch; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change only at posedge+1; in_ready is sampled at the negedge before acceptance.
  task automatic send(input logic [1:0] dest, input logic [31:0] d, input bit loads,
                      input logic [1:0] ch);
    @(posedge clk); #1;
    in_valid = 1'b1; in_dest = dest; in_data = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (loads) sb.push_back(exp_t'{ch, d});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && |(out_valid & out_ready)) begin
      if (sb.size() == 0) chk("sb_extra", 64'(sb.size()), 64'd1);
      else begin
        mon_e = sb.pop_front();
        chk("sb_sel", out_sel, mon_e.ch);
        chk("sb_data", out_data, mon_e.data);
        chk("sb_onehot", out_valid, 4'b0001 << mon_e.ch);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; chan_en = 4'hF; in_valid = 1'b0; in_data = '0;
    in_dest = '0; out_ready = 4'hF; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", cnt_out, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_data", out_data, 0);
    chk("idle_in_ready", in_ready, 1);

    // Directed, every channel once; valid one cycle after acceptance.
    for (int d = 0; d < 4; d++) begin
      send(2'(d), 32'hA0 + d, 1'b1, 2'(d));
      @(negedge clk); chk("dir_onehot", out_valid, 4'b0001 << d);
    end
    @(negedge clk); chk("dir_cnt", cnt_out, 8'h55);

    // Round-robin over channels 1 and 3 only.
    mode = 1'b1; chan_en = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      send(2'd0, 32'hB0 + i, 1'b1, (i % 2) ? 2'd3 : 2'd1);
      @(negedge clk); chk("rr_onehot", out_valid, (i % 2) ? 4'b1000 : 4'b0010);
    end

    // Backpressure on channel 2, then simultaneous drain and reload.
    mode = 1'b0; chan_en = 4'hF;
    @(posedge clk); #1 out_ready = 4'b1011;
    send(2'd2, 32'h55, 1'b1, 2'd2);
    in_valid = 1'b1; in_dest = 2'd3; in_data = 32'h66;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 4'b0100);
      chk("bp_data", out_data, 32'h55);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 4'hF;
    @(negedge clk);
    chk("bp_in_ready_drain", in_ready, 1);
    sb.push_back(exp_t'{2'd3, 32'h66});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_reload_valid", out_valid, 4'b1000);
    chk("bp_reload_data", out_data, 32'h66);

    // Directed to a disabled channel: swallowed with an error pulse.
    chan_en = 4'b1101;
    send(2'd1, 32'h77, 1'b0, 2'd1);
    @(negedge clk);
    chk("err_no_valid", out_valid, 0);
    chk("err_pulse_hi", err_pulse, 1);
    @(negedge clk); chk("err_pulse_lo", err_pulse, 0);
    mode = 1'b1; chan_en = 4'h0; in_valid = 1'b1;
    #1 chk("rr_none_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Counter clear, saturation, and clear beating a same-cycle increment.
    mode = 1'b0; chan_en = 4'hF;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk); chk("clr_all", cnt_out, 0);
    for (int i = 0; i < 5; i++) send(2'd0, 32'hC0 + i, 1'b1, 2'd0);
    @(negedge clk); @(negedge clk); chk("cnt_sat", cnt_out, 8'h03);
    send(2'd0, 32'hC5, 1'b1, 2'd0);
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk); chk("clr_wins", cnt_out, 0);

    // Advance the RR pointer, then reset while holding an item.
    mode = 1'b1; chan_en = 4'hF;
    send(2'd0, 32'hD0, 1'b1, 2'd0);
    @(posedge clk); #1 out_ready = 4'h0; mode = 1'b0;
    send(2'd2, 32'h99, 1'b1, 2'd2);
    @(negedge clk); chk("pre_rst_hold", out_valid, 4'b0100);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_cnt", cnt_out, 0);
    out_ready = 4'hF; mode = 1'b1;
    send(2'd3, 32'hE0, 1'b1, 2'd0);
    @(negedge clk); chk("post_rst_ptr", out_valid, 4'b0001);

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    @(posedge clk); #1 out_ready = 4'h0; mode = 1'b0;
    send(2'd1, 32'hBB, 1'b0, 2'd1);
    repeat (4) begin
      @(negedge clk);
      chk("to_hold_valid", out_valid, 4'b0010);
      chk("to_no_drop", drop_pulse, 0);
    end
    @(negedge clk);
    chk("to_drop", drop_pulse, 1);
    chk("to_idle", out_valid, 0);
    @(negedge clk); chk("to_drop_lo", drop_pulse, 0);
    @(posedge clk); #1 out_ready = 4'hF;
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
